// File: rtl/llc_read_arbiter.sv
// Shares the single LLC read port between L1-I and L1-D misses; D has priority, I is forced after STARVE_LIMIT D grants.
// Latency: request to LLC valid 1 cycle, LLC response to requester DATA_VALID 1 cycle, issue spacing >= 3 cycles.
// Backpressure: one transaction in flight; the other requester's level-held request waits in place until the port frees.
module llc_read_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int LINE_WIDTH   = 512,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] I_S_R_ADDR,
    input  logic                  I_S_R_ADDR_VALID,
    output logic [LINE_WIDTH-1:0] I_S_R_DATA,
    output logic                  I_S_R_DATA_VALID,
    input  logic [ADDR_WIDTH-1:0] D_S_R_ADDR,
    input  logic                  D_S_R_ADDR_VALID,
    output logic [LINE_WIDTH-1:0] D_S_R_DATA,
    output logic                  D_S_R_DATA_VALID,
    output logic [ADDR_WIDTH-1:0] L2_S_R_ADDR,
    output logic                  L2_S_R_ADDR_VALID,
    input  logic [LINE_WIDTH-1:0] L2_S_R_DATA,
    input  logic                  L2_S_R_DATA_VALID,
    output logic                  grant_owner
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    l2_vld_q, l2_vld_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    i_vld_q, i_vld_d;
    logic                    d_vld_q, d_vld_d;
    logic                    owner_q, owner_d;
    logic [SW-1:0]           streak_q, streak_d;
    logic                    pick_d;
    logic                    owner_live;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        l2_vld_d = l2_vld_q;
        line_d   = line_q;
        i_vld_d  = 1'b0;
        d_vld_d  = 1'b0;
        owner_d  = owner_q;
        streak_d = streak_q;

        pick_d     = D_S_R_ADDR_VALID &&
                     !(I_S_R_ADDR_VALID && (STARVE_LIMIT != 0) && (streak_q == LIMIT));
        // L2_S_R_ADDR doubles as the latched address of the outstanding request
        owner_live = owner_q ? (D_S_R_ADDR_VALID && (D_S_R_ADDR == addr_q))
                             : (I_S_R_ADDR_VALID && (I_S_R_ADDR == addr_q));

        case (state_q)
            IDLE: begin
                if (I_S_R_ADDR_VALID || D_S_R_ADDR_VALID) begin
                    state_d  = WAIT;
                    l2_vld_d = 1'b1;
                    owner_d  = pick_d;
                    addr_d   = pick_d ? D_S_R_ADDR : I_S_R_ADDR;
                    if (pick_d && I_S_R_ADDR_VALID)
                        streak_d = (streak_q == LIMIT) ? streak_q : streak_q + 1'b1;
                    else
                        streak_d = '0;
                end
            end
            WAIT: begin
                if (L2_S_R_DATA_VALID) begin
                    l2_vld_d = 1'b0;
                    line_d   = L2_S_R_DATA;
                    if (owner_live) begin
                        state_d = RESP;
                        if (owner_q) d_vld_d = 1'b1;
                        else         i_vld_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            l2_vld_q <= 1'b0;
            line_q   <= '0;
            i_vld_q  <= 1'b0;
            d_vld_q  <= 1'b0;
            owner_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            l2_vld_q <= l2_vld_d;
            line_q   <= line_d;
            i_vld_q  <= i_vld_d;
            d_vld_q  <= d_vld_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    assign L2_S_R_ADDR       = addr_q;
    assign L2_S_R_ADDR_VALID = l2_vld_q;
    assign I_S_R_DATA        = line_q;
    assign D_S_R_DATA        = line_q;
    assign I_S_R_DATA_VALID  = i_vld_q;
    assign D_S_R_DATA_VALID  = d_vld_q;
    assign grant_owner       = owner_q;

endmodule

// File: doc/llc_read_arbiter.md
Name: llc_read_arbiter

Overview:
Shares the single LLC read port (512-bit line fill) between the L1-I and L1-D miss paths, replacing ad hoc muxing at top level. Accepts level-held read requests from both L1s, issues one request at a time to the LLC, and returns the line only to the owning requester. L1-D has priority, and a starvation limit guarantees L1-I forward progress.

Parameters:
ADDR_WIDTH, 64, request address width
LINE_WIDTH, 512, cache line width returned by LLC
STARVE_LIMIT, 4, consecutive D grants allowed while I is pending before I is forced; 0 = strict D priority

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk)
I_S_R_ADDR  in  ADDR_WIDTH  L1-I line address
I_S_R_ADDR_VALID  in  1  L1-I request, level-held until served
I_S_R_DATA  out  LINE_WIDTH  returned line
I_S_R_DATA_VALID  out  1  one-cycle response pulse to L1-I
D_S_R_ADDR  in  ADDR_WIDTH  L1-D line address
D_S_R_ADDR_VALID  in  1  L1-D request, level-held until served
D_S_R_DATA  out  LINE_WIDTH  returned line
D_S_R_DATA_VALID  out  1  one-cycle response pulse to L1-D
L2_S_R_ADDR  out  ADDR_WIDTH  address to LLC
L2_S_R_ADDR_VALID  out  1  LLC request, held until L2_S_R_DATA_VALID
L2_S_R_DATA  in  LINE_WIDTH  LLC line data
L2_S_R_DATA_VALID  in  1  LLC response pulse
grant_owner  out  1  0=I, 1=D; owner of current or last transaction (debug)

Behaviour:
- All outputs are registered. Reset (reset==0): state IDLE; L2_S_R_ADDR=0, L2_S_R_ADDR_VALID=0; both DATA_VALID=0; line register=0 (I_S_R_DATA=D_S_R_DATA=0); grant_owner=0; streak counter=0.
- Reset asserted mid-transaction aborts it. The LLC request drops the cycle after reset is sampled. Any LLC response arriving afterwards is ignored because the block is in IDLE.
- Requester contract: hold ADDR stable while ADDR_VALID is high. Deassert ADDR_VALID by the first edge after DATA_VALID is seen.
- States: IDLE, WAIT, RESP.
- IDLE: if any ADDR_VALID is high, select a winner. Register L2_S_R_ADDR=winner addr, L2_S_R_ADDR_VALID=1, grant_owner=winner, latched_addr=winner addr. Go to WAIT. The grant takes 1 cycle from request to LLC valid. If there is no request, stay in IDLE. L2_S_R_DATA_VALID seen in IDLE is ignored.
- Winner selection:
  - Only one requester valid: that requester wins.
  - Both valid: D wins, unless STARVE_LIMIT!=0 and streak==STARVE_LIMIT, in which case I wins.
- Streak counter update on each grant:
  - Grant to D while I_S_R_ADDR_VALID=1: streak+1, saturating at STARVE_LIMIT.
  - Grant to I, or grant to D with I idle: streak=0.
- WAIT: hold L2_S_R_ADDR and L2_S_R_ADDR_VALID. On L2_S_R_DATA_VALID=1:
  - L2_S_R_ADDR_VALID<=0 and line register<=L2_S_R_DATA.
  - If the owner's ADDR_VALID is still 1 and the owner's ADDR==latched_addr: owner's DATA_VALID<=1 and go to RESP.
  - Otherwise (owner cancelled, e.g. a fetch redirected on a jump): discard the data, no pulse, go to IDLE.
- Cancel does not abort the LLC transaction. The arbiter stays in WAIT until the LLC responds.
- RESP: the owner's DATA_VALID is high for exactly this cycle, then returns to 0. Go to IDLE. The non-owner's DATA_VALID is never asserted.
- Latency: LLC response edge to requester DATA_VALID is 1 cycle. A new arbitration can start in the IDLE cycle following RESP. Minimum issue spacing is 3 cycles.
- I_S_R_DATA and D_S_R_DATA both drive the line register. Only the DATA_VALID signals are steered to one requester.
- A requester that raises ADDR_VALID while the other owns the port waits; no request is lost.
- A request whose ADDR changes while it is pending and not owned is sampled fresh at the next grant.

Test Plan:
- Single I request addr 0x1000; LLC responds 5 cycles after L2 valid with data D0 -> L2_S_R_ADDR=0x1000 one cycle after request; I_S_R_DATA_VALID pulses 1 cycle with I_S_R_DATA=D0; D_S_R_DATA_VALID stays 0.
- I (0x2000) and D (0x8040) assert in the same cycle -> D issued first; I issued in the IDLE cycle after D's RESP; each gets only its own line.
- STARVE_LIMIT=4, D re-requests continuously, I pending at 0x3000 -> grants D,D,D,D,I; streak resets to 0 after the I grant.
- I requests 0x4000, then drops ADDR_VALID in WAIT (jump) -> L2 valid held until the LLC response; no I_S_R_DATA_VALID; returns to IDLE; next request 0x5000 is served normally.
- reset driven to 0 during WAIT, then released; LLC response arrives later -> all outputs 0 after the reset edge; late response ignored; no DATA_VALID pulse.
- Spurious L2_S_R_DATA_VALID while IDLE -> no output change, state stays IDLE.
